vector_list_seq: RTL and testbench
==================================

# vector_list_seq

Parametrised display-list sequencer that walks a vector memory, decodes move/draw/end entries, and feeds start/end coordinate pairs to the line drawer (bresenham) over a go/busy/done handshake. Successor to vector_manage, adding:
- configurable coordinate and address widths and memory read latency;
- bank-selectable display lists;
- zero-length-line suppression;
- a frame counter;
- optional frame clamping.

Sits between the vector RAM and the line rasteriser.

## Interface
- IN_WIDTH, 8: unsigned coordinate width read from memory.
- OFF_WIDTH, 8: address offset width within one display list.
- BANK_BITS, 1: bank select width; ADR_WIDTH = BANK_BITS + OFF_WIDTH.
- RD_LAT, 1: register stages in the memory read path.
- FRAME_MIN, 0 / FRAME_MAX, 255: clamp bounds (used only with VECTOR_CLAMP_EN).
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock.
  - rst  in  1  synchronous active-high reset.
- en  in  1  run enable, sampled only in IDLE.
- bank  in  BANK_BITS  display-list select, latched at frame start.
- x, y  in  IN_WIDTH  entry coordinates from memory.
- line, pos  in  1  entry type bits.
- busy  in  1  line drawer busy.
- done  in  1  line drawer one-cycle completion pulse.
- adr  out  ADR_WIDTH  memory address {bank_q, offset}.
- go  out  1  one-cycle line start pulse.
- stax, stay, endx, endy  out  IN_WIDTH+1 signed  line endpoints, zero-extended.
- vector_reset  out  1  one-cycle end-of-frame pulse.
- frame_count  out  16  completed frames, wraps at 65535->0.

## Operation
States: IDLE, FETCH, DECODE, SEND, WAITBUSY, WAITDONE, ENDFRAME.

Entry decode (pos, line):
- 1,0 MOVE: cursor <= (x, y); no draw.
- 0,1 DRAW: line from cursor to (x, y), then cursor <= (x, y).
- 0,0 NOP: skipped.
- 1,1 END: terminates the list.

State transitions:
- IDLE: when en=1, latch bank_q <= bank, offset <= 0 -> FETCH.
- FETCH: adr driven; waits RD_LAT+1 cycles -> DECODE.
- DECODE, by entry type:
  - MOVE/NOP: offset+1 -> FETCH.
  - DRAW: load stax/stay = cursor, endx/endy = (x, y). If start equals end, update the cursor and skip without asserting go. Otherwise -> SEND.
  - END -> ENDFRAME.
- SEND: go=1 for one cycle -> WAITBUSY.
- WAITBUSY: waits for busy=1 or done=1. If done=1 -> offset+1, FETCH; else -> WAITDONE.
- WAITDONE: on done=1 -> offset+1, FETCH.
- ENDFRAME: vector_reset=1 for one cycle; frame_count+1; cursor kept. Next state:
  - en=1: re-latch bank, offset <= 0 -> FETCH.
  - en=0: -> IDLE.
- Wrap: an entry at offset 2^OFF_WIDTH-1 that is not END is processed normally, then the block goes to ENDFRAME (implicit end of list).
- en deassert mid-frame: frame completes; the block stops at ENDFRAME.
- bank change mid-frame: ignored until the next frame start.
- stax..endy are held stable from SEND until the next DRAW decode.

## Timing
- Reset values:
  - State IDLE; adr=0; go=0; vector_reset=0; frame_count=0.
  - stax, stay, endx, endy = 0; cursor = (0,0); bank_q=0.
- adr is registered; the entry is sampled exactly RD_LAT+1 edges after adr changes.
- Per-entry cost: MOVE/NOP/skipped DRAW take RD_LAT+2 cycles.
- go rises the cycle after DECODE and never overlaps busy=1 from a prior line.
- done in the same cycle as go is ignored; only done after SEND is accepted.
- rst mid-line: immediate return to reset values; the drawer is reset by the same rst.

## Configuration
- VECTOR_CLAMP_EN defined: each sampled coordinate is saturated to [FRAME_MIN, FRAME_MAX] before use as cursor or endpoint.
- VECTOR_CLAMP_EN undefined: coordinates pass unchanged; FRAME_MIN and FRAME_MAX are unused.

## Structure
- Shared package vector_pkg holds:
  - the state enum;
  - entry-type localparams (MOVE, DRAW, NOP, END) encoded as {pos, line};
  - the vector entry struct {x, y, line, pos}.
- One sub-module, vector_clamp: combinational saturation of one coordinate, instantiated twice inside a VECTOR_CLAMP_EN guard.

## Test plan
- List {MOVE(0,0), MOVE(200,200), DRAW(150,90), END} with bresenham -> exactly one go, stax=200, stay=200, endx=150, endy=90; one vector_reset pulse; frame_count=1.
- DRAW(150,90) directly following MOVE(150,90) -> no go; adr advances after RD_LAT+2 cycles.
- 2^OFF_WIDTH entries with no END -> vector_reset pulse after offset 255; adr returns to {bank_q, 0}.
- bank toggled 0->1 mid-frame -> adr MSB stays 0 until vector_reset, then reads from 256.
- With VECTOR_CLAMP_EN and FRAME_MAX=200: DRAW(255,254) -> endx=200, endy=200.
- rst asserted during WAITDONE -> next cycle go=0, adr=0, all coordinates 0; three consecutive frames then give frame_count=3.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the display-list sequencer: FSM state codes, entry-type
// encodings ({pos, line}) and the decoded vector entry record.
package vector_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_FETCH    = 3'd1;
  localparam state_t ST_DECODE   = 3'd2;
  localparam state_t ST_SEND     = 3'd3;
  localparam state_t ST_WAITBUSY = 3'd4;
  localparam state_t ST_WAITDONE = 3'd5;
  localparam state_t ST_ENDFRAME = 3'd6;

  localparam logic [1:0] ENT_NOP  = 2'b00;
  localparam logic [1:0] ENT_DRAW = 2'b01;
  localparam logic [1:0] ENT_MOVE = 2'b10;
  localparam logic [1:0] ENT_END  = 2'b11;

  // Coordinates are carried at this width internally; IN_WIDTH must not exceed it.
  localparam int VEC_COORD_MAX_W = 16;

  typedef struct packed {
    logic [VEC_COORD_MAX_W-1:0] x;
    logic [VEC_COORD_MAX_W-1:0] y;
    logic                       line;
    logic                       pos;
  } vector_entry_t;

  function automatic logic [1:0] entry_type(input vector_entry_t e);
    return {e.pos, e.line};
  endfunction

endpackage

// File: rtl/vector_list_seq_if.sv
// Bus between the sequencer, the vector RAM read port and the line drawer.
// master = sequencer side, slave = memory/drawer side.
interface vector_list_seq_if #(
  parameter int IN_WIDTH  = 8,
  parameter int ADR_WIDTH = 9,
  parameter int BANK_BITS = 1
);
  logic                       en;
  logic [BANK_BITS-1:0]       bank;
  logic [IN_WIDTH-1:0]        x;
  logic [IN_WIDTH-1:0]        y;
  logic                       line;
  logic                       pos;
  logic                       busy;
  logic                       done;
  logic [ADR_WIDTH-1:0]       adr;
  logic                       go;
  logic signed [IN_WIDTH:0]   stax;
  logic signed [IN_WIDTH:0]   stay;
  logic signed [IN_WIDTH:0]   endx;
  logic signed [IN_WIDTH:0]   endy;
  logic                       vector_reset;
  logic [15:0]                frame_count;

  modport master (
    input  en, bank, x, y, line, pos, busy, done,
    output adr, go, stax, stay, endx, endy, vector_reset, frame_count
  );

  modport slave (
    output en, bank, x, y, line, pos, busy, done,
    input  adr, go, stax, stay, endx, endy, vector_reset, frame_count
  );
endinterface

// File: rtl/vector_clamp.sv
// Combinational saturation of one unsigned coordinate to [MIN_VAL, MAX_VAL].
module vector_clamp #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 255
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_VAL);

  always_comb begin
    dout = din;
    if (din <= LO)
      dout = LO;
    else if (din >= HI)
      dout = HI;
  end
endmodule

// File: rtl/vector_list_seq.sv
// Display-list sequencer: walks vector RAM, decodes MOVE/DRAW/NOP/END and hands
// line endpoints to the drawer. Define VECTOR_CLAMP_EN to saturate coordinates.
module vector_list_seq
  import vector_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OFF_WIDTH = 8,
  parameter int BANK_BITS = 1,
  parameter int RD_LAT    = 1,
  parameter int FRAME_MIN = 0,
  parameter int FRAME_MAX = 255
) (
  input logic             clk,
  input logic             rst,
  vector_list_seq_if.master bus
);
  localparam int ADR_WIDTH = BANK_BITS + OFF_WIDTH;
  localparam int WAIT_W    = $clog2(RD_LAT + 2);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(RD_LAT);
  localparam logic [OFF_WIDTH-1:0] OFF_LAST  = {OFF_WIDTH{1'b1}};

  state_t                     state_q, state_d;
  logic [OFF_WIDTH-1:0]       offset_q, offset_d;
  logic [BANK_BITS-1:0]       bank_q, bank_d;
  logic [ADR_WIDTH-1:0]       adr_q, adr_d;
  logic [WAIT_W-1:0]          wait_q, wait_d;
  vector_entry_t              entry_q, entry_d;
  logic [VEC_COORD_MAX_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [IN_WIDTH-1:0]        stax_q, stax_d, stay_q, stay_d;
  logic [IN_WIDTH-1:0]        endx_q, endx_d, endy_q, endy_d;
  logic                       go_q, go_d;
  logic                       vr_q, vr_d;
  logic [15:0]                frame_q, frame_d;
  logic                       advance;
  logic                       finish;
  logic [IN_WIDTH-1:0]        samp_x, samp_y;

`ifdef VECTOR_CLAMP_EN
  vector_clamp #(.WIDTH(IN_WIDTH), .MIN_VAL(FRAME_MIN), .MAX_VAL(FRAME_MAX)) u_clamp_x (
    .din  (bus.x),
    .dout (samp_x)
  );
  vector_clamp #(.WIDTH(IN_WIDTH), .MIN_VAL(FRAME_MIN), .MAX_VAL(FRAME_MAX)) u_clamp_y (
    .din  (bus.y),
    .dout (samp_y)
  );
`else
  assign samp_x = bus.x;
  assign samp_y = bus.y;
  // Clamp bounds only matter when clamping is built in.
  if (FRAME_MIN > FRAME_MAX) begin : g_unused_bounds
  end
`endif

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    bank_d   = bank_q;
    adr_d    = adr_q;
    wait_d   = wait_q;
    entry_d  = entry_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    stax_d   = stax_q;
    stay_d   = stay_q;
    endx_d   = endx_q;
    endy_d   = endy_q;
    frame_d  = frame_q;
    go_d     = 1'b0;
    vr_d     = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ENDFRAME: begin
        if (bus.en) begin
          bank_d   = bus.bank;
          offset_d = '0;
          adr_d    = {bus.bank, {OFF_WIDTH{1'b0}}};
          wait_d   = '0;
          state_d  = ST_FETCH;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          entry_d.x    = VEC_COORD_MAX_W'(samp_x);
          entry_d.y    = VEC_COORD_MAX_W'(samp_y);
          entry_d.line = bus.line;
          entry_d.pos  = bus.pos;
          state_d      = ST_DECODE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DECODE: begin
        case (entry_type(entry_q))
          ENT_DRAW: begin
            stax_d  = cur_x_q[IN_WIDTH-1:0];
            stay_d  = cur_y_q[IN_WIDTH-1:0];
            endx_d  = entry_q.x[IN_WIDTH-1:0];
            endy_d  = entry_q.y[IN_WIDTH-1:0];
            cur_x_d = entry_q.x;
            cur_y_d = entry_q.y;
            // A zero-length line never reaches the drawer.
            if ((cur_x_q == entry_q.x) && (cur_y_q == entry_q.y)) begin
              advance = 1'b1;
            end else begin
              go_d    = 1'b1;
              state_d = ST_SEND;
            end
          end
          ENT_MOVE: begin
            cur_x_d = entry_q.x;
            cur_y_d = entry_q.y;
            advance = 1'b1;
          end
          ENT_END:  finish  = 1'b1;
          default:  advance = 1'b1;
        endcase
      end
      ST_SEND:     state_d = ST_WAITBUSY;
      ST_WAITBUSY: begin
        if (bus.done)
          advance = 1'b1;
        else if (bus.busy)
          state_d = ST_WAITDONE;
      end
      ST_WAITDONE: begin
        if (bus.done)
          advance = 1'b1;
      end
      default:     state_d = ST_IDLE;
    endcase

    // The last slot of a list ends the frame even without an END entry.
    if (advance) begin
      if (offset_q == OFF_LAST) begin
        finish = 1'b1;
      end else begin
        offset_d = offset_q + 1'b1;
        adr_d    = {bank_q, offset_q + 1'b1};
        wait_d   = '0;
        state_d  = ST_FETCH;
      end
    end

    if (finish) begin
      vr_d    = 1'b1;
      frame_d = frame_q + 16'd1;
      state_d = ST_ENDFRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      bank_q   <= '0;
      adr_q    <= '0;
      wait_q   <= '0;
      entry_q  <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      stax_q   <= '0;
      stay_q   <= '0;
      endx_q   <= '0;
      endy_q   <= '0;
      go_q     <= 1'b0;
      vr_q     <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      bank_q   <= bank_d;
      adr_q    <= adr_d;
      wait_q   <= wait_d;
      entry_q  <= entry_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      stax_q   <= stax_d;
      stay_q   <= stay_d;
      endx_q   <= endx_d;
      endy_q   <= endy_d;
      go_q     <= go_d;
      vr_q     <= vr_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.adr          = adr_q;
  assign bus.go           = go_q;
  assign bus.stax         = {1'b0, stax_q};
  assign bus.stay         = {1'b0, stay_q};
  assign bus.endx         = {1'b0, endx_q};
  assign bus.endy         = {1'b0, endy_q};
  assign bus.vector_reset = vr_q;
  assign bus.frame_count  = frame_q;

endmodule

// File: tb/tb_vector_list_seq.sv
// Directed bench for vector_list_seq: RAM model with one read stage, a simple
// line-drawer model, and hand-computed expectations per display list.
module tb_vector_list_seq;
  localparam int IN_WIDTH  = 8;
  localparam int OFF_WIDTH = 8;
  localparam int BANK_BITS = 1;
  localparam int RD_LAT    = 1;
  localparam int ADR_WIDTH = BANK_BITS + OFF_WIDTH;

  localparam logic [1:0] T_NOP  = 2'b00;
  localparam logic [1:0] T_DRAW = 2'b01;
  localparam logic [1:0] T_MOVE = 2'b10;
  localparam logic [1:0] T_END  = 2'b11;

`ifdef VECTOR_CLAMP_EN
  localparam int EXP_CLAMP_X = 200;
  localparam int EXP_CLAMP_Y = 200;
`else
  localparam int EXP_CLAMP_X = 255;
  localparam int EXP_CLAMP_Y = 254;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  vector_list_seq_if #(.IN_WIDTH(IN_WIDTH), .ADR_WIDTH(ADR_WIDTH), .BANK_BITS(BANK_BITS)) bus ();

  vector_list_seq #(
    .IN_WIDTH  (IN_WIDTH),
    .OFF_WIDTH (OFF_WIDTH),
    .BANK_BITS (BANK_BITS),
    .RD_LAT    (RD_LAT),
    .FRAME_MIN (0),
    .FRAME_MAX (200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // vector RAM with a single registered read stage
  logic [7:0] mem_x [512];
  logic [7:0] mem_y [512];
  logic [1:0] mem_t [512];
  logic [7:0] rd_x, rd_y;
  logic [1:0] rd_t;

  always @(posedge clk) begin
    rd_x <= mem_x[bus.adr];
    rd_y <= mem_y[bus.adr];
    rd_t <= mem_t[bus.adr];
  end

  assign bus.x    = rd_x;
  assign bus.y    = rd_y;
  assign bus.pos  = rd_t[1];
  assign bus.line = rd_t[0];

  // line drawer: busy for draw_len cycles after go, then a one-cycle done
  int   draw_len = 3;
  int   draw_cnt;
  logic drw_busy, drw_done;

  always @(posedge clk) begin
    if (rst) begin
      drw_busy <= 1'b0;
      drw_done <= 1'b0;
      draw_cnt <= 0;
    end else begin
      drw_done <= 1'b0;
      if (bus.go) begin
        drw_busy <= 1'b1;
        draw_cnt <= draw_len;
      end else if (drw_busy) begin
        if (draw_cnt <= 1) begin
          drw_busy <= 1'b0;
          drw_done <= 1'b1;
        end else begin
          draw_cnt <= draw_cnt - 1;
        end
      end
    end
  end

  assign bus.busy = drw_busy;
  assign bus.done = drw_done;

  // pulse monitors, sampled mid-cycle
  int go_count = 0;
  int vr_count = 0;
  int cap_stax, cap_stay, cap_endx, cap_endy;

  always @(negedge clk) begin
    if (bus.go === 1'b1) begin
      go_count = go_count + 1;
      cap_stax = int'(bus.stax);
      cap_stay = int'(bus.stay);
      cap_endx = int'(bus.endx);
      cap_endy = int'(bus.endy);
    end
    if (bus.vector_reset === 1'b1)
      vr_count = vr_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic setEntry(input int a, input logic [1:0] t, input int xv, input int yv);
    mem_t[a] = t;
    mem_x[a] = 8'(xv);
    mem_y[a] = 8'(yv);
  endtask

  // one-cycle run request while the sequencer sits in IDLE
  task automatic applyStimulus(input logic [BANK_BITS-1:0] bnk);
    @(posedge clk);
    #1 bus.en = 1'b1;
    bus.bank = bnk;
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic waitFrameEnd(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.vector_reset === 1'b1) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  go0, vr0, t0, t1, t2, last_adr;
    bit  seen, msb_seen;

    bus.en   = 1'b0;
    bus.bank = '0;
    for (int i = 0; i < 512; i++) setEntry(i, T_NOP, 0, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_adr",   32'(bus.adr), 32'd0);
    checkOutput("rst_go",    32'(bus.go), 32'd0);
    checkOutput("rst_vr",    32'(bus.vector_reset), 32'd0);
    checkOutput("rst_frame", 32'(bus.frame_count), 32'd0);
    checkOutput("rst_stax",  32'(bus.stax), 32'd0);
    checkOutput("rst_stay",  32'(bus.stay), 32'd0);
    checkOutput("rst_endx",  32'(bus.endx), 32'd0);
    checkOutput("rst_endy",  32'(bus.endy), 32'd0);

    // basic list: one line from (200,200) to (150,90)
    setEntry(0, T_MOVE, 0, 0);
    setEntry(1, T_MOVE, 200, 200);
    setEntry(2, T_DRAW, 150, 90);
    setEntry(3, T_END, 0, 0);
    go0 = go_count;
    vr0 = vr_count;
    applyStimulus(1'b0);
    waitFrameEnd("t1_frame_end", 200);
    settle();
    checkOutput("t1_go_pulses", 32'(go_count - go0), 32'd1);
    checkOutput("t1_go_stax",   32'(cap_stax), 32'd200);
    checkOutput("t1_go_stay",   32'(cap_stay), 32'd200);
    checkOutput("t1_go_endx",   32'(cap_endx), 32'd150);
    checkOutput("t1_go_endy",   32'(cap_endy), 32'd90);
    checkOutput("t1_vr_pulses", 32'(vr_count - vr0), 32'd1);
    checkOutput("t1_frame",     32'(bus.frame_count), 32'd1);
    checkOutput("t1_endx_held", 32'(bus.endx), 32'd150);

    // zero-length draw is suppressed; per-entry cost is RD_LAT+2
    setEntry(0, T_MOVE, 150, 90);
    setEntry(1, T_DRAW, 150, 90);
    setEntry(2, T_END, 0, 0);
    go0 = go_count;
    t0 = -1; t1 = -1; t2 = -1; seen = 1'b0;
    applyStimulus(1'b0);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.adr == 9'd0 && t0 < 0) t0 = i;
      if (bus.adr == 9'd1 && t1 < 0) t1 = i;
      if (bus.adr == 9'd2 && t2 < 0) t2 = i;
      if (bus.vector_reset === 1'b1) seen = 1'b1;
    end
    checkOutput("t2_frame_end", 32'(seen), 32'd1);
    checkOutput("t2_move_cost", 32'(t1 - t0), 32'(RD_LAT + 2));
    checkOutput("t2_skip_cost", 32'(t2 - t1), 32'(RD_LAT + 2));
    settle();
    checkOutput("t2_no_go",     32'(go_count - go0), 32'd0);
    checkOutput("t2_frame",     32'(bus.frame_count), 32'd2);

    // full list without END wraps; bank change mid-frame takes effect next frame
    for (int i = 0; i < 256; i++) setEntry(i, T_NOP, 0, 0);
    setEntry(256, T_END, 0, 0);
    @(posedge clk);
    #1 bus.en = 1'b1;
    bus.bank = 1'b0;
    seen = 1'b0; msb_seen = 1'b0; last_adr = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bus.vector_reset === 1'b1) begin
        seen = 1'b1;
      end else begin
        msb_seen = msb_seen | bus.adr[8];
        last_adr = int'(bus.adr);
      end
      if (i == 100) bus.bank = 1'b1;
    end
    checkOutput("t3_wrap_end",  32'(seen), 32'd1);
    checkOutput("t3_bank_msb",  32'(msb_seen), 32'd0);
    checkOutput("t3_last_adr",  32'(last_adr), 32'd255);
    @(posedge clk);
    #1 bus.en = 1'b0;
    @(negedge clk);
    checkOutput("t3_next_adr",  32'(bus.adr), 32'd256);
    waitFrameEnd("t3_bank1_end", 100);
    settle();
    checkOutput("t3_frame",     32'(bus.frame_count), 32'd4);

    // large endpoint; saturated only when clamping is built in
    setEntry(0, T_MOVE, 10, 20);
    setEntry(1, T_DRAW, 255, 254);
    setEntry(2, T_END, 0, 0);
    applyStimulus(1'b0);
    waitFrameEnd("t4_frame_end", 200);
    settle();
    checkOutput("t4_stax",  32'(bus.stax), 32'd10);
    checkOutput("t4_stay",  32'(bus.stay), 32'd20);
    checkOutput("t4_endx",  32'(bus.endx), 32'(EXP_CLAMP_X));
    checkOutput("t4_endy",  32'(bus.endy), 32'(EXP_CLAMP_Y));
    checkOutput("t4_frame", 32'(bus.frame_count), 32'd5);

    // reset while the drawer is busy, then three back-to-back frames
    setEntry(0, T_MOVE, 5, 5);
    setEntry(1, T_DRAW, 100, 100);
    setEntry(2, T_END, 0, 0);
    draw_len = 20;
    go0 = go_count;
    seen = 1'b0;
    applyStimulus(1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (go_count != go0) seen = 1'b1;
    end
    checkOutput("t5_go_seen", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_rst_go",    32'(bus.go), 32'd0);
    checkOutput("t5_rst_adr",   32'(bus.adr), 32'd0);
    checkOutput("t5_rst_stax",  32'(bus.stax), 32'd0);
    checkOutput("t5_rst_stay",  32'(bus.stay), 32'd0);
    checkOutput("t5_rst_endx",  32'(bus.endx), 32'd0);
    checkOutput("t5_rst_endy",  32'(bus.endy), 32'd0);
    checkOutput("t5_rst_frame", 32'(bus.frame_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.en   = 1'b1;
    bus.bank = 1'b0;
    waitFrameEnd("t5_frame1_end", 300);
    waitFrameEnd("t5_frame2_end", 300);
    @(posedge clk);
    #1 bus.en = 1'b0;
    waitFrameEnd("t5_frame3_end", 300);
    settle();
    checkOutput("t5_frame",     32'(bus.frame_count), 32'd3);
    checkOutput("t5_go_endx",   32'(cap_endx), 32'd100);
    checkOutput("t5_go_stax",   32'(cap_stax), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
